// File: rtl/hack_mem_pkg.sv
// Shared address map, region/state enums and the address decoder for the Hack data memory.
package hack_mem_pkg;

  localparam logic [14:0] RAM_BASE = 15'h0000;
  localparam logic [14:0] SCR_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR = 15'h6000;

  typedef enum logic [1:0] {REG_RAM, REG_SCR, REG_KBD, REG_NONE} region_t;

  typedef enum logic {KBD_IDLE, KBD_HOLD} kbd_state_t;

  function automatic region_t decodeRegion(input logic [14:0] addr);
    region_t r;
    if ((addr - RAM_BASE) < (SCR_BASE - RAM_BASE))
      r = REG_RAM;
    else if (addr < KBD_ADDR)
      r = REG_SCR;
    else if (addr == KBD_ADDR)
      r = REG_KBD;
    else
      r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/hack_kbd_reg.sv
// Keyboard event capture: valid/ready accept, then a KBD_HOLD-cycle hold before the next event.
module hack_kbd_reg
  import hack_mem_pkg::*;
#(
  parameter int unsigned KBD_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        keyValid,
  input  logic [15:0] keyCode,
  output logic        keyReady,
  output logic [15:0] kbdReg
);

  localparam int unsigned CW = $clog2(KBD_HOLD + 1);

  kbd_state_t      state;
  logic [CW-1:0]   holdCnt;

  // keyReady is registered: it stays low through reset and rises on the first edge in idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= KBD_IDLE;
      holdCnt  <= '0;
      kbdReg   <= '0;
      keyReady <= 1'b0;
    end else begin
      case (state)
        KBD_IDLE: begin
          if (keyValid && keyReady) begin
            kbdReg   <= keyCode;
            holdCnt  <= CW'(KBD_HOLD - 1);
            state    <= hack_mem_pkg::KBD_HOLD;
            keyReady <= 1'b0;
          end else begin
            keyReady <= 1'b1;
          end
        end
        hack_mem_pkg::KBD_HOLD: begin
          if (holdCnt == '0) begin
            state    <= KBD_IDLE;
            keyReady <= 1'b1;
          end else begin
            holdCnt <= holdCnt - 1'b1;
          end
        end
        default: state <= KBD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hack_data_mem.sv
// Hack CPU data memory: RAM, screen with scan-out port, keyboard register.
// Optional sticky bus error on bad writes: define HACK_MEM_BUSERR_EN.
module hack_data_mem
  import hack_mem_pkg::*;
#(
  parameter int unsigned RAM_AW   = 14,
  parameter int unsigned SCR_AW   = 13,
  parameter int unsigned KBD_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [14:0]       addressM,
  input  logic [15:0]       outM,
  input  logic              writeM,
  output logic [15:0]       inM,
  input  logic              key_valid,
  input  logic [15:0]       key_code,
  output logic              key_ready,
  input  logic              scr_rd_en,
  input  logic [SCR_AW-1:0] scr_addr,
  output logic [15:0]       scr_data,
  output logic              scr_valid,
  output logic              bus_err
);

  logic [15:0] ram    [2**RAM_AW];
  logic [15:0] screen [2**SCR_AW];

  region_t           region;
  logic [RAM_AW-1:0] ramIdx;
  logic [SCR_AW-1:0] scrIdx;
  logic [15:0]       kbdReg;

  assign region = decodeRegion(addressM);
  assign ramIdx = addressM[RAM_AW-1:0];
  assign scrIdx = addressM[SCR_AW-1:0];

  always_ff @(posedge clk) begin
    if (writeM && region == REG_RAM)
      ram[ramIdx] <= outM;
  end

  always_ff @(posedge clk) begin
    if (writeM && region == REG_SCR)
      screen[scrIdx] <= outM;
  end

  // Scan read samples the pre-edge contents, so a same-edge CPU write is not seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scr_valid <= 1'b0;
      scr_data  <= '0;
    end else begin
      scr_valid <= scr_rd_en;
      if (scr_rd_en)
        scr_data <= screen[scr_addr];
    end
  end

  always_comb begin
    inM = '0;
    case (region)
      REG_RAM: inM = ram[ramIdx];
      REG_SCR: inM = screen[scrIdx];
      REG_KBD: inM = kbdReg;
      default: inM = '0;
    endcase
  end

  hack_kbd_reg #(
    .KBD_HOLD(KBD_HOLD)
  ) uKbd (
    .clk      (clk),
    .rst_n    (reset),
    .keyValid (key_valid),
    .keyCode  (key_code),
    .keyReady (key_ready),
    .kbdReg   (kbdReg)
  );

`ifdef HACK_MEM_BUSERR_EN
  logic busErr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      busErr <= 1'b0;
    else if (writeM && (region == REG_KBD || region == REG_NONE))
      busErr <= 1'b1;
  end

  assign bus_err = busErr;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_hack_data_mem.sv
// Directed self-checking bench for hack_data_mem (default parameters).
module tb_hack_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        key_valid;
  logic [15:0] key_code;
  logic        key_ready;
  logic        scr_rd_en;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_valid;
  logic        bus_err;

  int unsigned total = 0;
  int unsigned bad   = 0;

`ifdef HACK_MEM_BUSERR_EN
  localparam logic EXP_BUSERR = 1'b1;
`else
  localparam logic EXP_BUSERR = 1'b0;
`endif

  always #5 clk = ~clk;

  hack_data_mem #(
    .RAM_AW  (14),
    .SCR_AW  (13),
    .KBD_HOLD(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addressM (addressM),
    .outM     (outM),
    .writeM   (writeM),
    .inM      (inM),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .scr_rd_en(scr_rd_en),
    .scr_addr (scr_addr),
    .scr_data (scr_data),
    .scr_valid(scr_valid),
    .bus_err  (bus_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuWrite(input logic [14:0] a, input logic [15:0] d);
    addressM = a;
    outM     = d;
    writeM   = 1'b1;
    tick();
    writeM   = 1'b0;
  endtask

  task automatic waitReady();
    int unsigned n = 0;
    while (!key_ready && n < 50) begin
      tick();
      n++;
    end
    chk("waitReady", {15'd0, key_ready}, 16'd1);
  endtask

  initial begin
    int unsigned lowEdges;

    reset     = 1'b0;
    addressM  = 15'h6000;
    outM      = '0;
    writeM    = 1'b0;
    key_valid = 1'b0;
    key_code  = '0;
    scr_rd_en = 1'b0;
    scr_addr  = '0;

    tick();
    chk("rst_ready", {15'd0, key_ready}, 16'd0);
    chk("rst_sv", {15'd0, scr_valid}, 16'd0);
    chk("rst_sd", scr_data, 16'h0000);
    chk("rst_be", {15'd0, bus_err}, 16'd0);
    chk("rst_kbd", inM, 16'h0000);
    tick();
    reset = 1'b1;
    tick();
    chk("rel_ready", {15'd0, key_ready}, 16'd1);

    // RAM write then read
    cpuWrite(15'd1001, 16'd0);
    cpuWrite(15'd1000, 16'd12345);
    chk("ram1000", inM, 16'd12345);
    addressM = 15'd1001;
    #1;
    chk("ram1001", inM, 16'd0);

    // Screen write then scan read
    cpuWrite(15'h4000, 16'hFFFF);
    chk("scr_cpu_rd", inM, 16'hFFFF);
    scr_rd_en = 1'b1;
    scr_addr  = 13'd0;
    tick();
    scr_rd_en = 1'b0;
    chk("scan_valid", {15'd0, scr_valid}, 16'd1);
    chk("scan_data", scr_data, 16'hFFFF);
    tick();
    chk("scan_valid_drop", {15'd0, scr_valid}, 16'd0);
    chk("scan_data_hold", scr_data, 16'hFFFF);

    // Read-before-write collision
    cpuWrite(15'h4005, 16'h0000);
    addressM  = 15'h4005;
    outM      = 16'h1234;
    writeM    = 1'b1;
    scr_rd_en = 1'b1;
    scr_addr  = 13'd5;
    tick();
    writeM = 1'b0;
    chk("rbw_old", scr_data, 16'h0000);
    tick();
    scr_rd_en = 1'b0;
    chk("rbw_new", scr_data, 16'h1234);
    chk("rbw_cpu", inM, 16'h1234);

    // Keyboard accept and hold
    addressM  = 15'h6000;
    key_valid = 1'b1;
    key_code  = 16'd75;
    tick();
    key_code = 16'd0;
    chk("kbd_75", inM, 16'd75);
    chk("kbd_busy", {15'd0, key_ready}, 16'd0);
    lowEdges = 0;
    while (!key_ready && lowEdges < 40) begin
      tick();
      lowEdges++;
    end
    chk("hold_len", 16'(lowEdges), 16'd16);
    chk("hold_keep75", inM, 16'd75);
    tick();
    key_valid = 1'b0;
    chk("kbd_release", inM, 16'd0);
    chk("kbd_busy2", {15'd0, key_ready}, 16'd0);

    // Writes to KBD/unmapped are ignored
    cpuWrite(15'h6001, 16'hBEEF);
    chk("unmap_rd", inM, 16'h0000);
    chk("bus_err", {15'd0, bus_err}, {15'd0, EXP_BUSERR});
    cpuWrite(15'h6000, 16'h5555);
    chk("kbd_ro", inM, 16'h0000);
    addressM = 15'h7FFF;
    tick();
    chk("unmap_top", inM, 16'h0000);
    chk("bus_err_sticky", {15'd0, bus_err}, {15'd0, EXP_BUSERR});
    addressM = 15'd1000;
    #1;
    chk("ram_intact", inM, 16'd12345);

    // Reset in the middle of a hold
    addressM = 15'h6000;
    waitReady();
    key_valid = 1'b1;
    key_code  = 16'd75;
    tick();
    key_valid = 1'b0;
    chk("kbd_75b", inM, 16'd75);
    repeat (3) tick();
    scr_rd_en = 1'b1;
    scr_addr  = 13'd0;
    tick();
    scr_rd_en = 1'b0;
    chk("pre_rst_sv", {15'd0, scr_valid}, 16'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_kbd", inM, 16'h0000);
    chk("arst_ready", {15'd0, key_ready}, 16'd0);
    chk("arst_sv", {15'd0, scr_valid}, 16'd0);
    chk("arst_sd", scr_data, 16'h0000);
    chk("arst_be", {15'd0, bus_err}, 16'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_ready", {15'd0, key_ready}, 16'd1);
    chk("post_kbd", inM, 16'h0000);
    addressM = 15'd1000;
    #1;
    chk("ram_survives", inM, 16'd12345);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/hack_data_mem.md
Name: hack_data_mem

Overview:
- Data-memory responder for the Hack CPU: the memory end of the CPU's addressM/outM/writeM/inM interface.
- Decodes the Hack address map (RAM, screen, keyboard) and answers CPU reads with zero latency.
- Commits CPU writes on the clock edge.
- Captures keyboard events through a valid/ready handshake and serves a registered screen scan-out read port for the display reader.

Parameters:
- RAM_AW, 14, RAM word-address width (16K words at 0x0000-0x3FFF)
- SCR_AW, 13, screen word-address width (8K words at 0x4000-0x5FFF)
- KBD_HOLD, 16, minimum cycles a new key code stays visible before the next key event is accepted (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- addressM  in  15  CPU data address
- outM  in  16  CPU write data
- writeM  in  1  CPU write strobe
- inM  out  16  read data to CPU, combinational from addressM
- key_valid  in  1  keyboard event offered
- key_code  in  16  key code; 0 = all keys released
- key_ready  out  1  keyboard event accepted when key_valid&&key_ready
- scr_rd_en  in  1  scan-out read request
- scr_addr  in  13  scan-out word address
- scr_data  out  16  scan-out data
- scr_valid  out  1  scr_data valid (one cycle after scr_rd_en)
- bus_err  out  1  sticky unmapped-access flag (see Optional Feature)

Behaviour:
- Address map, decoded on addressM:
  - 0x0000-0x3FFF RAM
  - 0x4000-0x5FFF screen
  - 0x6000 KBD (read-only)
  - 0x6001-0x7FFF unmapped
- CPU read:
  - inM = word at addressM, same cycle, no register.
  - KBD returns the current key register.
  - Unmapped returns 0.
- CPU write: on the rising edge with writeM=1 to RAM or screen, the word updates; the new value is visible on inM from the next cycle. Writes to KBD or unmapped addresses are ignored.
- Scan port:
  - On the edge with scr_rd_en=1, scr_data <= screen[scr_addr] and scr_valid <= 1; otherwise scr_valid <= 0 and scr_data holds.
  - CPU write and scan read to the same word on the same edge: scan returns the old data (read-before-write).
- Keyboard FSM (states KBD_IDLE, KBD_HOLD):
  - KBD_IDLE: key_ready=1. On accept, kbd_reg <= key_code, hold counter <= KBD_HOLD-1, go to KBD_HOLD.
  - KBD_HOLD: key_ready=0. Counter decrements each cycle. At 0, go to KBD_IDLE.
  - A release event (code 0) is accepted and held like any other code.
  - Back-to-back events are spaced at least KBD_HOLD+1 cycles apart.
- Reset (asserted asynchronously):
  - kbd_reg=0, FSM=KBD_IDLE, counter=0, scr_valid=0, scr_data=0, bus_err=0.
  - key_ready=0 while reset=0; key_ready=1 on the first cycle after release.
  - RAM and screen contents are not cleared; the bench must write before reading.
  - Reset in KBD_HOLD aborts the hold.
- Address widths: addressM[13:0] indexes RAM; addressM[12:0] indexes the screen. Upper bits are used only for decode.

Optional Feature:
- HACK_MEM_BUSERR_EN defined:
  - bus_err goes to 1 on the edge after any CPU write to KBD or unmapped space.
  - Reads never set it.
  - It stays 1 until reset.
- Undefined: bus_err tied to 0 and no error logic is built.

Decomposition:
- Package hack_mem_pkg:
  - address-map constants RAM_BASE=0x0000, SCR_BASE=0x4000, KBD_ADDR=0x6000
  - region enum {REG_RAM, REG_SCR, REG_KBD, REG_NONE}
  - kbd state enum {KBD_IDLE, KBD_HOLD}
- Sub-module hack_kbd_reg holds the keyboard FSM, hold counter and key register, and exports kbd_reg and key_ready.

Test Plan:
- Write outM=12345 to addressM=1000 with writeM=1 -> next cycle, with addressM=1000 and writeM=0, inM=12345. Then addressM=1001 (pre-written 0) gives inM=0.
- Write 0xFFFF to addressM=0x4000 -> scr_rd_en=1 with scr_addr=0 gives scr_valid=1 and scr_data=0xFFFF one cycle later. scr_valid returns to 0 the following cycle.
- Same edge: CPU writes 0x1234 to 0x4005 and scan reads scr_addr=5 (old 0x0000) -> scr_data=0x0000; the next scan read gives 0x1234.
- key_valid=1 with key_code=75, KBD_HOLD=16 -> read 0x6000 gives inM=75:
  - key_ready=0 for 16 cycles, then 1.
  - key_code=0 offered during the hold is not accepted until key_ready=1, after which inM=0.
- Write to 0x6001 with writeM=1 -> inM stays 0 and nothing changes. With HACK_MEM_BUSERR_EN, bus_err=1 next cycle and stays 1 until reset.
- Assert reset=0 mid-hold (kbd_reg=75) -> asynchronously kbd_reg=0, key_ready=0 and scr_valid=0. After release, key_ready=1 and a read of 0x6000 gives 0.
